// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the serial digit adder and its verification model:
//   - state_e    : controller states (IDLE, RUN, DONE)
//   - calc_ndig  : number of digit slices for a WIDTH/DIGIT pair
//   - calc_cnt_w : digit counter width, wide enough to hold NDIG
//   - ovf_rule   : two's-complement overflow from operand and result MSBs
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Guarded against DIGIT < 1 so elaboration reaches the parameter check
    // in the top module instead of dividing by zero here.
    function automatic int calc_ndig(input int width, input int digit);
        return (digit < 1) ? 1 : width / digit;
    endfunction

    function automatic int calc_cnt_w(input int width, input int digit);
        return $clog2(calc_ndig(width, digit) + 1);
    endfunction

    // Overflow happens only when both operands share a sign and the result
    // sign differs from it. msb_b is the MSB of the effective (possibly
    // inverted) B operand.
    function automatic logic ovf_rule(input logic msb_a, input logic msb_b,
                                      input logic msb_s);
        return (msb_a == msb_b) && (msb_s != msb_a);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Purely combinational DIGIT-bit ripple-carry slice built from full-adder
// cells.
// Ports:
//   x, y : DIGIT-bit addends
//   ci   : carry-in
//   s    : DIGIT-bit sum
//   co   : carry-out of the top cell
// -----------------------------------------------------------------------------
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co = w_c[DIGIT];

endmodule

// File: rtl/serial_digit_adder.sv
// -----------------------------------------------------------------------------
// serial_digit_adder
// Multi-cycle adder/subtractor: processes WIDTH-bit operands DIGIT bits per
// clock through a single digit_adder slice, LSB digit first.
// Ports:
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   start         : request, accepted only in IDLE
//   sub           : 0 = a + b + cin, 1 = a - b (cin ignored); latched at accept
//   cin           : carry-in for add mode; latched at accept
//   a, b          : WIDTH-bit operands; latched at accept
//   sum           : registered result, holds the previous value during RUN
//   cout          : carry-out of the MSB (sub mode: 1 = no borrow)
//   ovf           : two's-complement overflow
//   busy          : high in RUN and DONE
//   done          : one-cycle pulse in the cycle after the result updates
// -----------------------------------------------------------------------------
module serial_digit_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);

    if ((DIGIT < 1) || ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_bad_param
        $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           r_state;
    state_e           w_state_next;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_partial;
    logic             r_carry;
    logic             r_msb_a;
    logic             r_msb_b;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_b_eff;
    logic [DIGIT-1:0] w_slice_s;
    logic             w_slice_co;
    logic [WIDTH-1:0] w_partial_next;
    logic             w_last;

    assign w_b_eff = sub ? ~b : b;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x  (r_a_sr[DIGIT-1:0]),
        .y  (r_b_sr[DIGIT-1:0]),
        .ci (r_carry),
        .s  (w_slice_s),
        .co (w_slice_co)
    );

    // New slice enters at the top; after NDIG shifts the first slice sits at
    // bit 0. Written as shift/or so DIGIT == WIDTH needs no empty part-select.
    assign w_partial_next = (r_partial >> DIGIT) | (WIDTH'(w_slice_s) << (WIDTH - DIGIT));

    // Counter still holds NDIG-1 on the edge that makes it NDIG.
    assign w_last = (r_cnt == CNT_W'(NDIG - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path through
    // the case statement can leave a value held (no inferred latch).
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: shift registers, carry and counter are reset along with the
    // outputs, so an aborted operation leaves no stale operand state behind.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_partial <= '0;
            r_carry   <= 1'b0;
            r_msb_a   <= 1'b0;
            r_msb_b   <= 1'b0;
            r_cnt     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr    <= a;
                        r_b_sr    <= w_b_eff;
                        r_partial <= '0;
                        r_carry   <= sub ? 1'b1 : cin;
                        r_msb_a   <= a[WIDTH-1];
                        r_msb_b   <= w_b_eff[WIDTH-1];
                        r_cnt     <= '0;
                    end
                end
                RUN: begin
                    r_a_sr    <= r_a_sr >> DIGIT;
                    r_b_sr    <= r_b_sr >> DIGIT;
                    r_partial <= w_partial_next;
                    r_carry   <= w_slice_co;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    // Outputs change only once, with the completed result.
                    if (w_last) begin
                        sum  <= w_partial_next;
                        cout <= w_slice_co;
                        ovf  <= ovf_rule(r_msb_a, r_msb_b, w_partial_next[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_digit_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_digit_adder
// Directed bench for serial_digit_adder. The main instance is WIDTH=8,
// DIGIT=2; four further instances cover DIGIT=1/4/8 at WIDTH=8 and DIGIT=3
// at WIDTH=12. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_digit_adder;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start, sub, cin;
    logic [7:0] a, b, sum;
    logic       cout, ovf, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_digit_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clock (clock), .resetn (resetn), .start (start), .sub (sub),
        .cin (cin), .a (a), .b (b), .sum (sum), .cout (cout), .ovf (ovf),
        .busy (busy), .done (done)
    );

    // Parameter-sweep instances share operand inputs; each has its own start.
    logic [3:0]  sw_start, sw_cout, sw_ovf, sw_busy, sw_done;
    logic        sw_sub, sw_cin;
    logic [11:0] sw_a, sw_b;
    logic [7:0]  sum_d1, sum_d4, sum_d8;
    logic [11:0] sum_w12;
    logic [11:0] sw_sum [4];

    assign sw_sum[0] = {4'h0, sum_d1};
    assign sw_sum[1] = {4'h0, sum_d4};
    assign sw_sum[2] = {4'h0, sum_d8};
    assign sw_sum[3] = sum_w12;

    serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clock (clock), .resetn (resetn), .start (sw_start[0]), .sub (sw_sub),
        .cin (sw_cin), .a (sw_a[7:0]), .b (sw_b[7:0]), .sum (sum_d1),
        .cout (sw_cout[0]), .ovf (sw_ovf[0]), .busy (sw_busy[0]), .done (sw_done[0])
    );
    serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clock (clock), .resetn (resetn), .start (sw_start[1]), .sub (sw_sub),
        .cin (sw_cin), .a (sw_a[7:0]), .b (sw_b[7:0]), .sum (sum_d4),
        .cout (sw_cout[1]), .ovf (sw_ovf[1]), .busy (sw_busy[1]), .done (sw_done[1])
    );
    serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clock (clock), .resetn (resetn), .start (sw_start[2]), .sub (sw_sub),
        .cin (sw_cin), .a (sw_a[7:0]), .b (sw_b[7:0]), .sum (sum_d8),
        .cout (sw_cout[2]), .ovf (sw_ovf[2]), .busy (sw_busy[2]), .done (sw_done[2])
    );
    serial_digit_adder #(.WIDTH(12), .DIGIT(3)) u_w12 (
        .clock (clock), .resetn (resetn), .start (sw_start[3]), .sub (sw_sub),
        .cin (sw_cin), .a (sw_a), .b (sw_b), .sum (sum_w12),
        .cout (sw_cout[3]), .ovf (sw_ovf[3]), .busy (sw_busy[3]), .done (sw_done[3])
    );

    // Arithmetic reference: plain integer add/subtract, overflow from the
    // signed result leaving the representable range. Returns {ovf, cout, sum}.
    function automatic logic [13:0] ref_model(input int width, input logic [11:0] av,
                                              input logic [11:0] bv, input logic subv,
                                              input logic cinv);
        longint mask, half, ua, ub, tot, sa, sb, r;
        logic [11:0] s;
        logic        c, o;
        mask = (longint'(1) << width) - 1;
        half = longint'(1) << (width - 1);
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        tot  = subv ? ua + ((~ub) & mask) + 1 : ua + ub + longint'(cinv);
        s    = 12'(tot & mask);
        c    = ((tot >> width) & 1) != 0;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        r    = subv ? sa - sb : sa + sb + longint'(cinv);
        o    = (r < -half) || (r > half - 1);
        return {o, c, s};
    endfunction

    // Issues one operation on the main instance starting from IDLE at a
    // falling edge. Sample index j = 0 is the falling edge right after the
    // accepting rising edge. Operand inputs are scrambled after accept.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic subv, input logic cinv,
                          output int lat, output int busy_cycles,
                          output int done_cycles, output bit held);
        logic [7:0] prev_sum;
        logic       prev_cout, prev_ovf;
        prev_sum  = sum;
        prev_cout = cout;
        prev_ovf  = ovf;
        a = av; b = bv; sub = subv; cin = cinv; start = 1'b1;
        lat = -1; busy_cycles = 0; done_cycles = 0; held = 1'b1;
        @(negedge clock);
        start = 1'b0; a = ~av; b = ~bv; sub = ~subv; cin = ~cinv;
        for (int j = 0; j < 30; j++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                if (lat < 0) lat = j;
            end else if (lat < 0 && (sum !== prev_sum || cout !== prev_cout || ovf !== prev_ovf)) begin
                held = 1'b0;
            end
            if (!busy && j > 0) break;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        sw_start = '0; sw_sub = 1'b0; sw_cin = 1'b0; sw_a = '0; sw_b = '0;
        #12;
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clock); resetn = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        int lat, bc, dc; bit held;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bc, dc, held);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
        checks++; if (bc !== 5) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 5", bc); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL add_done_pulses: got %0d expected 1", dc); end
        checks++; if (sum !== 8'h96) begin errors++; $display("FAIL add_sum: got %h expected 96", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf: got %b expected 1", ovf); end
    endtask

    task automatic test_sub();
        int lat, bc, dc; bit held;
        run_op(8'h10, 8'h20, 1'b1, 1'b0, lat, bc, dc, held);
        checks++; if (sum !== 8'hF0) begin errors++; $display("FAIL sub1_sum: got %h expected f0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub1_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub1_ovf: got %b expected 0", ovf); end
        // cin=1 must be ignored in subtract mode.
        run_op(8'h7F, 8'h80, 1'b1, 1'b1, lat, bc, dc, held);
        checks++; if (sum !== 8'hFF) begin errors++; $display("FAIL sub2_sum: got %h expected ff", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub2_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub2_ovf: got %b expected 1", ovf); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL sub2_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_add_cin();
        int lat, bc, dc; bit held;
        run_op(8'hFF, 8'h01, 1'b0, 1'b1, lat, bc, dc, held);
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL cin_hold_during_run: got %b expected 1", held); end
        checks++; if (sum !== 8'h01) begin errors++; $display("FAIL cin_sum: got %h expected 01", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL cin_cout: got %b expected 1", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL cin_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_start_while_busy();
        int dc, extra;
        a = 8'h01; b = 8'h02; sub = 1'b0; cin = 1'b0; start = 1'b1;
        dc = 0; extra = 0;
        @(negedge clock);
        // Second request pulsed once in RUN (j=1) and once in DONE (j=4).
        for (int j = 0; j < 30; j++) begin
            if (j == 1 || j == 4) begin
                a = 8'h11; b = 8'h22; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) dc++;
            if (!busy && j > 0) break;
            @(negedge clock);
        end
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            if (busy || done) extra++;
        end
        checks++; if (sum !== 8'h03) begin errors++; $display("FAIL busy_start_sum: got %h expected 03", sum); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL busy_start_done_pulses: got %0d expected 1", dc); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_dropped: got %0d busy cycles expected 0", extra); end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, dc, seen; bit held;
        seen = 0;
        a = 8'h21; b = 8'h10; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL midrst_sum: got %h expected 00", sum); end
        checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL midrst_flags: got cout=%b ovf=%b expected 0 0", cout, ovf);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (busy || done) seen++;
        end
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (busy || done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen); end
        run_op(8'h05, 8'h03, 1'b0, 1'b0, lat, bc, dc, held);
        checks++; if (sum !== 8'h08) begin errors++; $display("FAIL post_rst_sum: got %h expected 08", sum); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL post_rst_done_pulses: got %0d expected 1", dc); end
    endtask

    task automatic sweep_op(input int cfg, input int ndig, input logic [11:0] av,
                            input logic [11:0] bv, input logic subv, input logic cinv,
                            input logic [11:0] exp_sum, input logic exp_cout,
                            input logic exp_ovf);
        int          lat;
        logic [11:0] got_sum;
        logic        got_cout, got_ovf;
        lat = -1; got_sum = 'x; got_cout = 1'bx; got_ovf = 1'bx;
        sw_a = av; sw_b = bv; sw_sub = subv; sw_cin = cinv;
        sw_start[cfg] = 1'b1;
        @(negedge clock);
        sw_start = '0;
        for (int j = 0; j < 40; j++) begin
            if (sw_done[cfg] && lat < 0) begin
                lat      = j;
                got_sum  = sw_sum[cfg];
                got_cout = sw_cout[cfg];
                got_ovf  = sw_ovf[cfg];
            end
            if (!sw_busy[cfg] && j > 0) break;
            @(negedge clock);
        end
        checks++; if (lat !== ndig) begin
            errors++; $display("FAIL sweep%0d_latency a=%h b=%h: got %0d expected %0d", cfg, av, bv, lat, ndig);
        end
        checks++; if (got_sum !== exp_sum || got_cout !== exp_cout || got_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL sweep%0d_result a=%h b=%h sub=%b cin=%b: got %h/%b/%b expected %h/%b/%b",
                     cfg, av, bv, subv, cinv, got_sum, got_cout, got_ovf, exp_sum, exp_cout, exp_ovf);
        end
    endtask

    task automatic test_param_sweep();
        int          widths [4] = '{8, 8, 8, 12};
        int          ndigs  [4] = '{8, 2, 1, 4};
        logic [13:0] exp;
        logic [11:0] ra, rb;
        logic        rs, rc;
        for (int c = 0; c < 3; c++) begin
            sweep_op(c, ndigs[c], 12'h05A, 12'h03C, 1'b0, 1'b0, 12'h096, 1'b0, 1'b1);
            sweep_op(c, ndigs[c], 12'h07F, 12'h080, 1'b1, 1'b0, 12'h0FF, 1'b0, 1'b1);
        end
        sweep_op(3, 4, 12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
        sweep_op(3, 4, 12'h123, 12'h456, 1'b1, 1'b0, 12'hCCD, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            for (int n = 0; n < 4; n++) begin
                ra  = 12'($urandom);
                rb  = 12'($urandom);
                rs  = 1'($urandom);
                rc  = 1'($urandom);
                exp = ref_model(widths[c], ra, rb, rs, rc);
                sweep_op(c, ndigs[c], ra, rb, rs, rc, exp[11:0], exp[12], exp[13]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_add_cin();
        test_start_while_busy();
        test_reset_mid_op();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
- Parametrised multi-cycle adder/subtractor: successor to the single-shot 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, reusing one DIGIT-bit ripple slice.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Sits between switch/register inputs and LED/7-seg display logic on the board datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  mode, latched at accept: 0 = a+b+cin, 1 = a-b (a + ~b + 1; cin ignored).
- cin  in  1  carry-in for add mode; latched at accept.
- a  in  WIDTH  operand A; latched at accept.
- b  in  WIDTH  operand B; latched at accept.
- sum  out  WIDTH  registered result.
- cout  out  1  carry-out of the MSB; in sub mode 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when the result updates.

Behaviour:
- Reset (resetn=0, asynchronous, any state): state=IDLE; sum=0, cout=0, ovf=0, busy=0, done=0; digit counter, shift registers and carry cleared. The op in flight is discarded and no done is issued.
- Let NDIG = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b_eff = sub ? ~b : b, carry = sub ? 1 : cin, msb_a = a[WIDTH-1], msb_b = b_eff[WIDTH-1].
  - Clear the counter and go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - slice = A_sr[DIGIT-1:0] + B_sr[DIGIT-1:0] + carry.
  - Shift A_sr and B_sr right by DIGIT.
  - Shift the slice sum into the top of the partial register.
  - carry <= slice carry-out; counter++.
  - On the edge where the counter reaches NDIG, go to DONE and update the outputs:
    - sum <= partial.
    - cout <= final carry.
    - ovf <= (msb_a == msb_b) && (sum[WIDTH-1] != msb_a).
- DONE: done=1 for exactly this cycle; next edge goes to IDLE.
- Latency: start sampled at edge E0 → outputs update at edge E_NDIG → done high during the following cycle.
  - Minimum start-to-start spacing is NDIG+2 edges.
- start while busy (RUN or DONE): ignored, with no effect on the latched operands.
- Changes to a, b, sub or cin after accept do not affect the op in flight.
- sum/cout/ovf hold the previous result throughout RUN; partial values are never visible on the outputs.
- Edge cases:
  - DIGIT = WIDTH gives NDIG=1: a single RUN cycle.
  - DIGIT = 1 gives a bit-serial adder.
- Counter width: $clog2(NDIG+1); no wrap-around, because the counter is cleared at accept.
- Elaboration must fail if WIDTH % DIGIT != 0 or DIGIT < 1.

Decomposition:
- Shared package (adder_pkg) holds:
  - the state enum {IDLE, RUN, DONE};
  - a function computing NDIG and the counter width from WIDTH/DIGIT;
  - the overflow-rule function, shared with the verification model.
- One sub-module: digit_adder (parameter DIGIT; inputs x, y, ci; outputs s, co).
  - Purely combinational ripple chain of full-adder cells.
  - Instantiated once in the datapath.

Test Plan:
- WIDTH=8, DIGIT=2, add: a=0x5A, b=0x3C, cin=0 → sum=0x96, cout=0, ovf=1. done pulses 4 cycles after the start edge; busy=1 for 5 cycles.
- Sub: a=0x10, b=0x20 → sum=0xF0, cout=0 (borrow), ovf=0. Then a=0x7F, b=0x80 → sum=0xFF, cout=0, ovf=1.
- Add with carry-in: a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1, ovf=0. Prior sum stays unchanged during RUN.
- Start while busy: pulse start with a=0x11, b=0x22 during RUN of op a=0x01, b=0x02 → result 0x03. Only one done pulse; the second request is dropped.
- Reset mid-op: drive resetn=0 asynchronously (between edges) during RUN cycle 2 → sum=0, cout=0, ovf=0, busy=0 immediately and no done. After release, start a=0x05, b=0x03 → sum=0x08 with normal latency.
- Parameter sweep: WIDTH=8 with DIGIT=1, 4, 8, and WIDTH=12 with DIGIT=3, on random vectors against a reference model. Latency must be 8, 2, 1 and 4 cycles respectively, and all results must match.
